set_pc: RTL and testbench
=========================

Name: set_pc

Overview:
- 8-bit program-counter register for the small CPU datapath; holds the address of the current instruction.
- Advances by STEP on each rising edge of the i_incPc request. Can be loaded with an absolute target from i_pcIn.
- Sits between the control unit (which issues the inc and load requests) and the instruction-memory address input.

Parameters:
- WIDTH, 8, PC width in bits; applies to i_pcIn and o_pcOut.
- STEP, 1, amount added per increment event, modulo 2^WIDTH.
- RESET_VAL, 0, value o_pcOut takes during reset.

Ports:
- i_clk  input  1  single system clock; all state updates on its rising edge.
- i_reset  input  1  synchronous, active-low reset (0 = reset, 1 = run).
- i_incPc  input  1  increment request; level signal from control, acted on at its 0->1 transition.
- i_loadPc  input  1  load request; level-sensitive, acted on every cycle it is high.
- i_pcIn  input  WIDTH  load value / jump target.
- o_pcOut  output  WIDTH  registered program counter.
- o_wrap  output  1  one-cycle pulse when an increment overflows past 2^WIDTH-1.

Behaviour:
- Reset is synchronous and active-low. On a rising i_clk edge with i_reset=0:
  - o_pcOut <= RESET_VAL and o_wrap <= 0.
  - The internal i_incPc history flop <= 0.
- Edge detection:
  - An internal flop samples i_incPc each cycle.
  - inc_evt = i_incPc & ~inc_q.
  - Holding i_incPc high for N cycles yields exactly one increment.
  - The first cycle after reset release with i_incPc already high counts as an edge, because the history flop was cleared.
- Priority each cycle, with i_reset=1:
  - If i_loadPc=1: o_pcOut <= i_pcIn. A coincident inc_evt is dropped, not deferred.
  - Else if inc_evt=1: o_pcOut <= o_pcOut + STEP, truncated to WIDTH bits.
  - Else: o_pcOut holds.
- Latency: o_pcOut reflects an accepted request one clock after the edge where it is sampled. No combinational path from any input to o_pcOut.
- Wrap: o_wrap=1 for exactly the one cycle after an increment whose unwrapped sum is >= 2^WIDTH, e.g. 8'hFF + 1 -> 8'h00. It is 0 in every other case, including loads.
- Reset mid-operation: reset wins over load and increment in the same cycle. No pending event survives reset.
- Unused/X: i_pcIn is ignored unless i_loadPc=1.

Decomposition:
- Shared package pc_pkg:
  - PC_WIDTH = 8.
  - pc_t, a logic vector of PC_WIDTH bits.
  - PC_RESET_VAL = 0.
- One natural sub-module: rise_detect. It contains the single history flop and the AND, has a synchronous active-low reset, and outputs a 1-cycle pulse. set_pc instantiates it for i_incPc.

Test Plan:
- Reset: hold i_reset=0 for 3 clocks with i_incPc toggling and i_pcIn=8'h55 -> o_pcOut=8'h00, o_wrap=0 throughout.
- Increment sequence: i_reset=1, i_pcIn=0, i_incPc alternating 0/1 every 2 clocks for 4 high phases -> o_pcOut steps 0,1,2,3,4, each change one clock after the 0->1 transition.
- Held request: i_incPc high for 10 consecutive clocks -> o_pcOut increases by exactly 1.
- Load priority: o_pcOut=8'h03, assert i_loadPc=1, i_pcIn=8'hA0 in the same cycle as an i_incPc rising edge -> o_pcOut=8'hA0 next cycle, no increment, o_wrap=0.
- Wrap: load 8'hFE, then two inc edges -> o_pcOut FE->FF->00; o_wrap=1 only in the cycle o_pcOut becomes 00.
- Reset mid-run: o_pcOut=8'h42; drive i_reset=0 together with i_loadPc=1 and an inc edge -> o_pcOut=8'h00 next cycle. After release with i_incPc still high, one increment to 8'h01.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared types and constants for the program-counter slice of the CPU datapath.
package pc_pkg;

    localparam int unsigned PC_WIDTH = 8;

    typedef logic [PC_WIDTH-1:0] pc_t;

    localparam pc_t PC_RESET_VAL = '0;

endpackage

// File: rtl/set_pc_rise_detect.sv
// Rising-edge detector: a single history flop and an AND give a one-cycle pulse.
module rise_detect (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_sig,
    output logic o_pulse
);

    logic sig_d;
    logic sig_q;

    always_comb begin
        sig_d = i_sig;
    end

    // The history is cleared in reset, so a level already high at release counts as an edge.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            sig_q <= 1'b0;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign o_pulse = i_sig & ~sig_q;

endmodule

// File: rtl/set_pc.sv
// Program-counter register: load has priority over an edge-detected increment.
module set_pc
    import pc_pkg::*;
#(
    parameter int unsigned       WIDTH     = PC_WIDTH,
    parameter int unsigned       STEP      = 1,
    parameter logic [WIDTH-1:0]  RESET_VAL = WIDTH'(PC_RESET_VAL)
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_incPc,
    input  logic             i_loadPc,
    input  logic [WIDTH-1:0] i_pcIn,
    output logic [WIDTH-1:0] o_pcOut,
    output logic             o_wrap
);

    localparam logic [WIDTH:0] STEP_EXT = {1'b0, WIDTH'(STEP)};

    logic             inc_evt;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] pc_d;
    logic [WIDTH-1:0] pc_q;
    logic             wrap_d;
    logic             wrap_q;

    rise_detect u_inc_edge (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_sig   (i_incPc),
        .o_pulse (inc_evt)
    );

    // The extra carry bit of the sum is exactly the overflow flag.
    always_comb begin
        sum    = {1'b0, pc_q} + STEP_EXT;
        pc_d   = pc_q;
        wrap_d = 1'b0;
        if (i_loadPc) begin
            pc_d = i_pcIn;
        end else if (inc_evt) begin
            pc_d   = sum[WIDTH-1:0];
            wrap_d = sum[WIDTH];
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            pc_q   <= RESET_VAL;
            wrap_q <= 1'b0;
        end else begin
            pc_q   <= pc_d;
            wrap_q <= wrap_d;
        end
    end

    assign o_pcOut = pc_q;
    assign o_wrap  = wrap_q;

endmodule

// File: tb/tb_set_pc.sv
// Self-checking bench for set_pc: directed scenarios plus randomized traffic against an integer model.
module tb_set_pc;

    logic       i_clk = 1'b0;
    logic       i_reset;
    logic       i_incPc;
    logic       i_loadPc;
    logic [7:0] i_pcIn;
    logic [7:0] o_pcOut;
    logic       o_wrap;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    // Behavioural model: PC as an integer, last seen request level, expected wrap flag.
    int unsigned m_pc       = 0;
    bit          m_wrap     = 1'b0;
    bit          m_prev_inc = 1'b0;

    set_pc dut (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_incPc  (i_incPc),
        .i_loadPc (i_loadPc),
        .i_pcIn   (i_pcIn),
        .o_pcOut  (o_pcOut),
        .o_wrap   (o_wrap)
    );

    always #5 i_clk = ~i_clk;

    function automatic void model_edge();
        bit evt;
        if (!i_reset) begin
            m_pc       = 0;
            m_wrap     = 1'b0;
            m_prev_inc = 1'b0;
        end else begin
            evt        = i_incPc && !m_prev_inc;
            m_prev_inc = i_incPc;
            m_wrap     = 1'b0;
            if (i_loadPc) begin
                m_pc = int'(i_pcIn);
            end else if (evt) begin
                m_wrap = (m_pc + 1) > 255;
                m_pc   = (m_pc + 1) % 256;
            end
        end
    endfunction

    task automatic tick();
        model_edge();
        @(posedge i_clk);
        #1;
    endtask

    task automatic test_reset();
        i_reset  = 1'b0;
        i_loadPc = 1'b0;
        i_pcIn   = 8'h55;
        for (int i = 0; i < 3; i++) begin
            i_incPc = i[0];
            tick();
            n_tests++;
            if (o_pcOut !== 8'h00 || o_wrap !== 1'b0) begin
                n_fail++;
                $display("FAIL reset cyc%0d: pc=%h wrap=%b, want pc=00 wrap=0", i, o_pcOut, o_wrap);
            end
        end
        i_incPc = 1'b0;
        tick();
    endtask

    task automatic test_increment();
        int unsigned exp_pc = 0;
        i_reset  = 1'b1;
        i_pcIn   = 8'h00;
        i_loadPc = 1'b0;
        for (int p = 0; p < 4; p++) begin
            i_incPc = 1'b0;
            tick();
            tick();
            n_tests++;
            if (o_pcOut !== 8'(exp_pc)) begin
                n_fail++;
                $display("FAIL incr low%0d: pc=%h, want %h", p, o_pcOut, 8'(exp_pc));
            end
            i_incPc = 1'b1;
            tick();
            exp_pc++;
            n_tests++;
            if (o_pcOut !== 8'(exp_pc) || o_wrap !== 1'b0) begin
                n_fail++;
                $display("FAIL incr edge%0d: pc=%h wrap=%b, want %h/0", p, o_pcOut, o_wrap, 8'(exp_pc));
            end
            tick();
            n_tests++;
            if (o_pcOut !== 8'(exp_pc)) begin
                n_fail++;
                $display("FAIL incr hold%0d: pc=%h, want %h", p, o_pcOut, 8'(exp_pc));
            end
        end
        i_incPc = 1'b0;
        tick();
    endtask

    task automatic test_held();
        logic [7:0] start;
        start   = o_pcOut;
        i_incPc = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_tests++;
            if (o_pcOut !== start + 8'd1) begin
                n_fail++;
                $display("FAIL held cyc%0d: pc=%h, want %h", i, o_pcOut, start + 8'd1);
            end
        end
        i_incPc = 1'b0;
        tick();
    endtask

    task automatic test_load_priority();
        i_loadPc = 1'b1;
        i_pcIn   = 8'h03;
        tick();
        i_loadPc = 1'b0;
        i_pcIn   = 8'($urandom);
        tick();
        n_tests++;
        if (o_pcOut !== 8'h03) begin
            n_fail++;
            $display("FAIL load_setup: pc=%h, want 03", o_pcOut);
        end
        i_loadPc = 1'b1;
        i_pcIn   = 8'hA0;
        i_incPc  = 1'b1;
        tick();
        n_tests++;
        if (o_pcOut !== 8'hA0 || o_wrap !== 1'b0) begin
            n_fail++;
            $display("FAIL load_prio: pc=%h wrap=%b, want A0/0", o_pcOut, o_wrap);
        end
        i_loadPc = 1'b0;
        tick();
        n_tests++;
        if (o_pcOut !== 8'hA0) begin
            n_fail++;
            $display("FAIL load_dropped: pc=%h, want A0", o_pcOut);
        end
        i_incPc = 1'b0;
        tick();
    endtask

    task automatic test_wrap();
        logic [7:0] exp_pc [4] = '{8'hFF, 8'hFF, 8'h00, 8'h00};
        bit         exp_wr [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        i_loadPc = 1'b1;
        i_pcIn   = 8'hFE;
        tick();
        i_loadPc = 1'b0;
        n_tests++;
        if (o_pcOut !== 8'hFE || o_wrap !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_load: pc=%h wrap=%b, want FE/0", o_pcOut, o_wrap);
        end
        for (int i = 0; i < 4; i++) begin
            i_incPc = (i % 2 == 0);
            i_pcIn  = 8'($urandom);
            tick();
            n_tests++;
            if (o_pcOut !== exp_pc[i] || o_wrap !== exp_wr[i]) begin
                n_fail++;
                $display("FAIL wrap step%0d: pc=%h wrap=%b, want %h/%b", i, o_pcOut, o_wrap, exp_pc[i], exp_wr[i]);
            end
        end
        i_incPc = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_run();
        i_loadPc = 1'b1;
        i_pcIn   = 8'h42;
        tick();
        i_loadPc = 1'b0;
        tick();
        n_tests++;
        if (o_pcOut !== 8'h42) begin
            n_fail++;
            $display("FAIL midrst_setup: pc=%h, want 42", o_pcOut);
        end
        i_reset  = 1'b0;
        i_loadPc = 1'b1;
        i_pcIn   = 8'($urandom);
        i_incPc  = 1'b1;
        tick();
        n_tests++;
        if (o_pcOut !== 8'h00 || o_wrap !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_reset: pc=%h wrap=%b, want 00/0", o_pcOut, o_wrap);
        end
        i_reset  = 1'b1;
        i_loadPc = 1'b0;
        tick();
        n_tests++;
        if (o_pcOut !== 8'h01) begin
            n_fail++;
            $display("FAIL midrst_release: pc=%h, want 01", o_pcOut);
        end
        tick();
        n_tests++;
        if (o_pcOut !== 8'h01) begin
            n_fail++;
            $display("FAIL midrst_held: pc=%h, want 01", o_pcOut);
        end
        i_incPc = 1'b0;
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            i_reset  = ($urandom_range(0, 15) != 0);
            i_loadPc = ($urandom_range(0, 5) == 0);
            i_incPc  = $urandom_range(0, 1) == 1;
            i_pcIn   = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
            tick();
            n_tests++;
            if (o_pcOut !== 8'(m_pc) || o_wrap !== m_wrap) begin
                n_fail++;
                $display("FAIL random cyc%0d: pc=%h wrap=%b, want %h/%b", i, o_pcOut, o_wrap, 8'(m_pc), m_wrap);
            end
        end
        i_reset = 1'b1;
    endtask

    initial begin
        i_reset  = 1'b0;
        i_incPc  = 1'b0;
        i_loadPc = 1'b0;
        i_pcIn   = 8'h00;
        test_reset();
        test_increment();
        test_held();
        test_load_priority();
        test_wrap();
        test_reset_mid_run();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
